// File: rtl/nios2_system_key_pio.sv
// ============================================================================
// nios2_system_key_pio : Avalon-MM pushbutton PIO with debounce, falling-edge
//                        capture and maskable level interrupt.
// Revision 1.0
// ============================================================================
`default_nettype none

module nios2_system_key_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q,   sync1_d;
    logic [WIDTH-1:0] sync2_q,   sync2_d;
    logic [WIDTH-1:0] stable_q,  stable_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    logic             wr_en;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] clr_mask;

    assign wr_en = chipselect & ~write_n;

    if (WIDTH < 32) begin : g_unused_wdata
        logic unused_wdata;
        assign unused_wdata = ^writedata[31:WIDTH];
    end

    always_comb begin
        sync1_d  = in_port;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        fall     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                    fall[i]     = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // A new falling edge on the same clock as a W1C of that bit must survive.
    always_comb begin
        clr_mask  = '0;
        irqmask_d = irqmask_q;
        if (wr_en && address == 2'd3) begin
            clr_mask = writedata[WIDTH-1:0];
        end
        if (wr_en && address == 2'd2) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        edgecap_d = (edgecap_q & ~clr_mask) | fall;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            stable_q  <= '1;
            irqmask_q <= '0;
            edgecap_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = 32'(stable_q);
            2'd2:    readdata = 32'(irqmask_q);
            2'd3:    readdata = 32'(edgecap_q);
            default: readdata = '0;
        endcase
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule

`default_nettype wire
